// File: rtl/rbm_argmax_scorer_pkg.sv
// Shared constants for the RBM argmax scorer: default geometry and FSM state encodings.
package rbm_argmax_scorer_pkg;

   localparam int DEF_OUTPUT_DIM  = 10;
   localparam int DEF_W_BITLENGTH = 12;
   localparam int DEF_LABEL_WIDTH = 4;
   localparam int DEF_COUNT_WIDTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/rbm_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module rbm_sat_counter #(
   parameter int count_width = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   i_inc,
   input  logic                   i_clr,
   output logic [count_width-1:0] o_count
);

   logic [count_width-1:0] r_count;

   // Stick at all-ones instead of wrapping so long accuracy runs never under-report.
   always_ff @(posedge clock) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {count_width{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/rbm_argmax_scorer.sv
// Captures the class-score vector when Main finishes, scans it for the signed maximum,
// and keeps running totals of classified images and correct predictions.
module rbm_argmax_scorer
   import rbm_argmax_scorer_pkg::*;
#(
   parameter int output_dim  = DEF_OUTPUT_DIM,
   parameter int w_bitlength = DEF_W_BITLENGTH,
   parameter int label_width = DEF_LABEL_WIDTH,
   parameter int count_width = DEF_COUNT_WIDTH
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              finish,
   input  logic [output_dim*w_bitlength-1:0] OutputDataPort,
   input  logic [label_width-1:0]            label,
   input  logic                              clear_stats,
   output logic [label_width-1:0]            pred_label,
   output logic [w_bitlength-1:0]            pred_score,
   output logic                              pred_valid,
   output logic                              correct,
   output logic                              busy,
   output logic [count_width-1:0]            total_count,
   output logic [count_width-1:0]            correct_count
);

   localparam logic [label_width-1:0] LAST_IDX = label_width'(output_dim - 1);

   state_t                              r_state;
   state_t                              w_nextState;
   logic                                r_finishD;
   logic [output_dim*w_bitlength-1:0]   r_scores;
   logic [label_width-1:0]              r_lbl;
   logic [label_width-1:0]              r_idx;
   logic [label_width-1:0]              r_bestIdx;
   logic signed [w_bitlength-1:0]       r_bestVal;
   logic [label_width-1:0]              r_predLabel;
   logic [w_bitlength-1:0]              r_predScore;
   logic                                r_predValid;
   logic                                r_correct;
   logic                                r_busy;

   logic                                w_start;
   logic                                w_capture;
   logic                                w_result;
   logic signed [w_bitlength-1:0]       w_cand;
   logic                                w_greater;
   logic [label_width-1:0]              w_finalIdx;
   logic signed [w_bitlength-1:0]       w_finalVal;
   logic                                w_finalCorrect;

   assign w_start        = finish & ~r_finishD;
   assign w_cand         = r_scores[r_idx*w_bitlength +: w_bitlength];
   // Strict compare keeps the lowest index on ties.
   assign w_greater      = w_cand > r_bestVal;
   assign w_finalIdx     = w_greater ? r_idx : r_bestIdx;
   assign w_finalVal     = w_greater ? w_cand : r_bestVal;
   assign w_finalCorrect = (w_finalIdx == r_lbl);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_capture   = 1'b0;
      w_result    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_capture   = 1'b1;
               w_nextState = SCAN;
            end
         end
         SCAN: begin
            if (r_idx == LAST_IDX) begin
               w_result    = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // finish_d resets high so a finish level held through reset is not mistaken for a rise.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_finishD   <= 1'b1;
         r_scores    <= '0;
         r_lbl       <= '0;
         r_idx       <= '0;
         r_bestIdx   <= '0;
         r_bestVal   <= '0;
         r_predLabel <= '0;
         r_predScore <= '0;
         r_predValid <= 1'b0;
         r_correct   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_finishD   <= finish;
         r_predValid <= w_result;
         if (w_capture) begin
            r_scores  <= OutputDataPort;
            r_lbl     <= label;
            r_bestVal <= OutputDataPort[w_bitlength-1:0];
            r_bestIdx <= '0;
            r_idx     <= label_width'(1);
            r_busy    <= 1'b1;
         end else if (r_state == SCAN) begin
            r_bestVal <= w_finalVal;
            r_bestIdx <= w_finalIdx;
            r_idx     <= r_idx + 1'b1;
            if (w_result) begin
               r_predLabel <= w_finalIdx;
               r_predScore <= w_finalVal;
               r_correct   <= w_finalCorrect;
               r_busy      <= 1'b0;
            end
         end
      end
   end

   rbm_sat_counter #(.count_width(count_width)) u_totalCounter (
      .clock   (clock),
      .reset   (reset),
      .i_inc   (w_result),
      .i_clr   (clear_stats),
      .o_count (total_count)
   );

   rbm_sat_counter #(.count_width(count_width)) u_correctCounter (
      .clock   (clock),
      .reset   (reset),
      .i_inc   (w_result & w_finalCorrect),
      .i_clr   (clear_stats),
      .o_count (correct_count)
   );

   assign pred_label = r_predLabel;
   assign pred_score = r_predScore;
   assign pred_valid = r_predValid;
   assign correct    = r_correct;
   assign busy       = r_busy;

endmodule

// File: tb/tb_rbm_argmax_scorer.sv
// Directed scoreboard bench for rbm_argmax_scorer: a default instance plus a 2-bit-counter
// instance that exercises saturation and clear/result collisions.
module tb_rbm_argmax_scorer;

   localparam int D   = 10;
   localparam int W   = 12;
   localparam int LW  = 4;
   localparam int CW  = 16;
   localparam int CWS = 2;

   typedef struct {
      logic [LW-1:0] lbl;
      logic [W-1:0]  score;
      logic          corr;
      int            total;
      int            ccount;
   } exp_t;

   logic           clock;
   logic           reset;
   logic           finishMain;
   logic           finishSmall;
   logic           clrMain;
   logic           clrSmall;
   logic [D*W-1:0] scores;
   logic [LW-1:0]  lbl;

   logic [LW-1:0]  predLabelMain, predLabelSmall;
   logic [W-1:0]   predScoreMain, predScoreSmall;
   logic           predValidMain, predValidSmall;
   logic           correctMain, correctSmall;
   logic           busyMain, busySmall;
   logic [CW-1:0]  totalMain, correctCntMain;
   logic [CWS-1:0] totalSmall, correctCntSmall;

   exp_t qMain[$];
   exp_t qSmall[$];
   int   compared;
   int   mismatched;
   int   modelTotal[2];
   int   modelCorrect[2];
   int   pulses[2];

   rbm_argmax_scorer dutMain (
      .clock          (clock),
      .reset          (reset),
      .finish         (finishMain),
      .OutputDataPort (scores),
      .label          (lbl),
      .clear_stats    (clrMain),
      .pred_label     (predLabelMain),
      .pred_score     (predScoreMain),
      .pred_valid     (predValidMain),
      .correct        (correctMain),
      .busy           (busyMain),
      .total_count    (totalMain),
      .correct_count  (correctCntMain)
   );

   rbm_argmax_scorer #(.count_width(CWS)) dutSmall (
      .clock          (clock),
      .reset          (reset),
      .finish         (finishSmall),
      .OutputDataPort (scores),
      .label          (lbl),
      .clear_stats    (clrSmall),
      .pred_label     (predLabelSmall),
      .pred_score     (predScoreSmall),
      .pred_valid     (predValidSmall),
      .correct        (correctSmall),
      .busy           (busySmall),
      .total_count    (totalSmall),
      .correct_count  (correctCntSmall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic setAll(input int v);
      for (int i = 0; i < D; i++) scores[i*W +: W] = v[W-1:0];
   endtask

   task automatic setOne(input int i, input int v);
      scores[i*W +: W] = v[W-1:0];
   endtask

   // Reference model: independent signed argmax with lowest-index tie break.
   task automatic pushExpected(input int sel, input bit clr);
      exp_t e;
      int   best;
      int   bestIdx;
      int   maxCnt;
      logic signed [W-1:0] s;
      maxCnt  = (sel == 1) ? ((1 << CWS) - 1) : ((1 << CW) - 1);
      s       = scores[W-1:0];
      best    = int'(s);
      bestIdx = 0;
      for (int i = 1; i < D; i++) begin
         s = scores[i*W +: W];
         if (int'(s) > best) begin
            best    = int'(s);
            bestIdx = i;
         end
      end
      e.lbl   = LW'(bestIdx);
      e.score = W'(best);
      e.corr  = (LW'(bestIdx) == lbl);
      if (clr) begin
         modelTotal[sel]   = 0;
         modelCorrect[sel] = 0;
      end else begin
         if (modelTotal[sel] < maxCnt) modelTotal[sel]++;
         if (e.corr && modelCorrect[sel] < maxCnt) modelCorrect[sel]++;
      end
      e.total  = modelTotal[sel];
      e.ccount = modelCorrect[sel];
      if (sel == 1) qSmall.push_back(e);
      else          qMain.push_back(e);
   endtask

   // Scoreboard: compare every pred_valid pulse against the oldest queued expectation.
   always @(negedge clock) begin
      exp_t e;
      if (predValidMain) begin
         pulses[0]++;
         if (qMain.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL mainUnexpectedValid observed=1 expected=0");
         end else begin
            e = qMain.pop_front();
            checkOutput("mainPredLabel", 32'(predLabelMain), 32'(e.lbl));
            checkOutput("mainPredScore", 32'(predScoreMain), 32'(e.score));
            checkOutput("mainCorrect", 32'(correctMain), 32'(e.corr));
            checkOutput("mainTotal", 32'(totalMain), 32'(e.total));
            checkOutput("mainCorrectCnt", 32'(correctCntMain), 32'(e.ccount));
         end
      end
      if (predValidSmall) begin
         pulses[1]++;
         if (qSmall.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL smallUnexpectedValid observed=1 expected=0");
         end else begin
            e = qSmall.pop_front();
            checkOutput("smallPredLabel", 32'(predLabelSmall), 32'(e.lbl));
            checkOutput("smallPredScore", 32'(predScoreSmall), 32'(e.score));
            checkOutput("smallCorrect", 32'(correctSmall), 32'(e.corr));
            checkOutput("smallTotal", 32'(totalSmall), 32'(e.total));
            checkOutput("smallCorrectCnt", 32'(correctCntSmall), 32'(e.ccount));
         end
      end
   end

   function automatic logic validOf(input int sel);
      return (sel == 1) ? predValidSmall : predValidMain;
   endfunction

   task automatic setFinish(input int sel, input logic v);
      if (sel == 1) finishSmall = v;
      else          finishMain  = v;
   endtask

   // Drive one image, check the 9-cycle latency and the single-cycle pulse, then drop finish.
   task automatic applyStimulus(input int sel, input logic [LW-1:0] l, input bit clrAtEnd);
      int n;
      bit got;
      lbl = l;
      pushExpected(sel, clrAtEnd);
      @(posedge clock); #1;
      setFinish(sel, 1'b1);
      @(posedge clock);
      n   = 0;
      got = 0;
      while (n < 20 && !got) begin
         @(posedge clock);
         n++;
         #1;
         if (clrAtEnd && n == 8) clrSmall = 1'b1;
         if (n == 9) clrSmall = 1'b0;
         if (validOf(sel)) got = 1;
      end
      clrSmall = 1'b0;
      checkOutput("latency", 32'(n), 32'd9);
      @(posedge clock); #1;
      checkOutput("pulseOneCycle", 32'(validOf(sel)), 32'd0);
      setFinish(sel, 1'b0);
      @(posedge clock); #1;
   endtask

   task automatic resetModel();
      qMain.delete();
      qSmall.delete();
      for (int i = 0; i < 2; i++) begin
         modelTotal[i]   = 0;
         modelCorrect[i] = 0;
      end
   endtask

   task automatic checkMainIdleZero(input string tag);
      checkOutput({tag, "Label"}, 32'(predLabelMain), 32'd0);
      checkOutput({tag, "Score"}, 32'(predScoreMain), 32'd0);
      checkOutput({tag, "Valid"}, 32'(predValidMain), 32'd0);
      checkOutput({tag, "Correct"}, 32'(correctMain), 32'd0);
      checkOutput({tag, "Busy"}, 32'(busyMain), 32'd0);
      checkOutput({tag, "Total"}, 32'(totalMain), 32'd0);
      checkOutput({tag, "CorrectCnt"}, 32'(correctCntMain), 32'd0);
   endtask

   task automatic loadImage1();
      setAll(0);
      setOne(0, 5);
      setOne(1, -3);
      setOne(2, 12);
      setOne(3, 7);
      setOne(9, 2);
   endtask

   task automatic loadImage2();
      setAll(32'h800);
      setOne(9, 32'h7FF);
   endtask

   initial begin
      int p0;
      compared    = 0;
      mismatched  = 0;
      pulses[0]   = 0;
      pulses[1]   = 0;
      reset       = 1'b1;
      finishMain  = 1'b0;
      finishSmall = 1'b0;
      clrMain     = 1'b0;
      clrSmall    = 1'b0;
      lbl         = '0;
      scores      = '0;
      resetModel();
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      checkMainIdleZero("reset");

      $display("[TB] basic argmax");
      loadImage1();
      applyStimulus(0, 4'd2, 1'b0);
      loadImage2();
      applyStimulus(0, 4'd3, 1'b0);
      setAll(-1);
      setOne(4, 100);
      setOne(6, 100);
      applyStimulus(0, 4'd4, 1'b0);

      $display("[TB] finish held through reset");
      finishMain = 1'b1;
      @(posedge clock); #1 reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      resetModel();
      p0 = pulses[0];
      repeat (15) @(posedge clock);
      #1;
      checkOutput("heldFinishNoValid", 32'(pulses[0] - p0), 32'd0);
      checkOutput("heldFinishNotBusy", 32'(busyMain), 32'd0);
      finishMain = 1'b0;
      @(posedge clock); #1;
      loadImage1();
      applyStimulus(0, 4'd2, 1'b0);

      $display("[TB] finish pulsed during scan");
      loadImage2();
      lbl = 4'd9;
      pushExpected(0, 1'b0);
      p0 = pulses[0];
      finishMain = 1'b1;
      @(posedge clock);
      repeat (3) @(posedge clock);
      #1 finishMain = 1'b0;
      checkOutput("scanBusy", 32'(busyMain), 32'd1);
      @(posedge clock); #1 finishMain = 1'b1;
      repeat (15) @(posedge clock);
      #1;
      checkOutput("scanRetriggerOnePulse", 32'(pulses[0] - p0), 32'd1);
      finishMain = 1'b0;
      @(posedge clock); #1;

      $display("[TB] reset mid-scan");
      loadImage1();
      lbl = 4'd2;
      p0 = pulses[0];
      finishMain = 1'b1;
      @(posedge clock);
      repeat (5) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      resetModel();
      checkMainIdleZero("midScanReset");
      repeat (15) @(posedge clock);
      #1;
      checkOutput("midScanNoValid", 32'(pulses[0] - p0), 32'd0);
      finishMain = 1'b0;
      @(posedge clock); #1;

      $display("[TB] saturation and clear collision");
      loadImage1();
      for (int k = 0; k < 5; k++) applyStimulus(1, 4'd2, 1'b0);
      checkOutput("satTotal", 32'(totalSmall), 32'd3);
      checkOutput("satCorrect", 32'(correctCntSmall), 32'd3);
      loadImage2();
      applyStimulus(1, 4'd3, 1'b1);
      checkOutput("clearTotal", 32'(totalSmall), 32'd0);
      checkOutput("clearCorrect", 32'(correctCntSmall), 32'd0);
      checkOutput("clearLabelUpdated", 32'(predLabelSmall), 32'd9);

      repeat (3) @(posedge clock);
      #1;
      checkOutput("mainQueueDrained", 32'(qMain.size()), 32'd0);
      checkOutput("smallQueueDrained", 32'(qSmall.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
